// File: rtl/hmmm_loader_pkg.sv
// Shared definitions for the hmmm boot/IO sequencer.
//   HMMM_ADDR_W / HMMM_DATA_W : default RAM address and bus word widths.
//   state_t                   : 3-bit loader state encoding.
package hmmm_loader_pkg;
  localparam int HMMM_ADDR_W = 8;
  localparam int HMMM_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RSTC      = 3'd1,
    ST_WAIT_WORD = 3'd2,
    ST_ADDR      = 3'd3,
    ST_DATA      = 3'd4,
    ST_RUN       = 3'd5,
    ST_HALTED    = 3'd6
  } state_t;
endpackage

// File: rtl/hmmm_loader_if.sv
// Signal bundle between the host wrapper / hmmm core and the loader.
//   host load side : load_start, abort, load_len, word_valid/word_data/word_ready
//   core side      : core_rst, pgrm_addr, pgrm_data, bus_out, bus_oe, bus_in,
//                    core_read, core_write, core_halt
//   host io side   : in_valid/in_data/in_ready, out_valid/out_data
//   status         : running, done, io_underflow
// modport slave is the loader; modport master is everything around it.
interface hmmm_loader_if
  import hmmm_loader_pkg::*;
#(
  parameter int ADDR_W = HMMM_ADDR_W,
  parameter int DATA_W = HMMM_DATA_W
);
  logic              load_start;
  logic              abort;
  logic [ADDR_W-1:0] load_len;
  logic              word_valid;
  logic [DATA_W-1:0] word_data;
  logic              word_ready;
  logic              core_rst;
  logic              pgrm_addr;
  logic              pgrm_data;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_in;
  logic              core_read;
  logic              core_write;
  logic              core_halt;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              running;
  logic              done;
  logic              io_underflow;

  modport slave (
    input  load_start, abort, load_len, word_valid, word_data,
           bus_in, core_read, core_write, core_halt, in_valid, in_data,
    output word_ready, core_rst, pgrm_addr, pgrm_data, bus_out, bus_oe,
           in_ready, out_valid, out_data, running, done, io_underflow
  );

  modport master (
    output load_start, abort, load_len, word_valid, word_data,
           bus_in, core_read, core_write, core_halt, in_valid, in_data,
    input  word_ready, core_rst, pgrm_addr, pgrm_data, bus_out, bus_oe,
           in_ready, out_valid, out_data, running, done, io_underflow
  );
endinterface

// File: rtl/hmmm_loader_io.sv
// RUN-phase in/out servicing for the hmmm core.
//   clk, rst     : clock, async active-high reset
//   running      : enables all servicing (loader is in RUN)
//   clr          : clears the sticky underflow flag
//   core_read    : core executes an in instruction
//   core_write   : core executes an out instruction and drives bus_in
//   bus_in       : sampled hmmm bus
//   in_valid/in_data/in_ready : host input stream (in_ready is combinational)
//   bus_out/bus_oe            : loader's contribution to the shared bus
//   out_valid/out_data        : one-cycle pulse carrying the word the core wrote
//   io_underflow              : sticky, core read with no input available
module hmmm_loader_io
  import hmmm_loader_pkg::*;
#(
  parameter int DATA_W = HMMM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              clr,
  input  logic              core_read,
  input  logic              core_write,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              io_underflow
);
  logic              rd_active;
  logic              wr_active;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              underflow_reg;

  assign rd_active = running & core_read;
  assign wr_active = running & core_write;
  assign in_ready  = rd_active & in_valid;
  // Never contend with the core: it owns the bus during an out instruction.
  assign bus_oe    = rd_active & ~core_write;
  // Starved reads see zero rather than stale data; the core is not stalled.
  assign bus_out   = in_ready ? in_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      underflow_reg <= 1'b0;
    end else begin
      out_valid_reg <= wr_active;
      if (wr_active) out_data_reg <= bus_in;
      if (clr) underflow_reg <= 1'b0;
      else if (rd_active & ~in_valid) underflow_reg <= 1'b1;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign io_underflow = underflow_reg;
endmodule

// File: rtl/hmmm_loader.sv
// Boot/IO sequencer for one hmmm core: holds the core in reset, streams a
// program into core RAM (address cycle then data cycle per word), releases the
// core and services its in/out instructions until halt.
//   clk  : system clock (shared with the core)
//   rst  : asynchronous active-high reset
//   lif  : hmmm_loader_if.slave carrying the host, core and status signals
module hmmm_loader
  import hmmm_loader_pkg::*;
#(
  parameter int ADDR_W = HMMM_ADDR_W,
  parameter int DATA_W = HMMM_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  hmmm_loader_if.slave  lif
);
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [DATA_W-1:0] word_reg, word_next;
  logic [ADDR_W-1:0] count_inc;
  logic              start_ok;
  logic              running;
  logic              io_bus_oe;
  logic [DATA_W-1:0] io_bus_out;

  assign count_inc = count_reg + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      addr_reg  <= '0;
      count_reg <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      word_reg  <= word_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    word_next  = word_reg;
    start_ok   = 1'b0;
    if (lif.abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (lif.load_start) begin
            start_ok   = 1'b1;
            len_next   = lif.load_len;
            addr_next  = '0;
            count_next = '0;
            // Zero length keeps the existing RAM image and just runs it.
            state_next = (lif.load_len == '0) ? ST_RUN : ST_WAIT_WORD;
          end
        end
        ST_HALTED: begin
          if (lif.load_start) begin
            start_ok   = 1'b1;
            len_next   = lif.load_len;
            state_next = ST_RSTC;
          end
        end
        ST_RSTC: begin
          addr_next  = '0;
          count_next = '0;
          state_next = (len_reg == '0) ? ST_RUN : ST_WAIT_WORD;
        end
        ST_WAIT_WORD: begin
          if (lif.word_valid) begin
            word_next  = lif.word_data;
            state_next = ST_ADDR;
          end
        end
        ST_ADDR: state_next = ST_DATA;
        ST_DATA: begin
          addr_next  = addr_reg + ADDR_W'(1);
          count_next = count_inc;
          state_next = (count_inc == len_reg) ? ST_RUN : ST_WAIT_WORD;
        end
        ST_RUN: begin
          if (lif.core_halt) state_next = ST_HALTED;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign running = (state_reg == ST_RUN);

  hmmm_loader_io #(.DATA_W(DATA_W)) u_io (
    .clk          (clk),
    .rst          (rst),
    .running      (running),
    .clr          (start_ok | lif.abort),
    .core_read    (lif.core_read),
    .core_write   (lif.core_write),
    .bus_in       (lif.bus_in),
    .in_valid     (lif.in_valid),
    .in_data      (lif.in_data),
    .in_ready     (lif.in_ready),
    .bus_out      (io_bus_out),
    .bus_oe       (io_bus_oe),
    .out_valid    (lif.out_valid),
    .out_data     (lif.out_data),
    .io_underflow (lif.io_underflow)
  );

  // All state-decoded outputs come straight off state_reg, so an async reset
  // drops them immediately and word_ready has no path from word_valid.
  assign lif.core_rst   = (state_reg == ST_IDLE) | (state_reg == ST_RSTC);
  assign lif.word_ready = (state_reg == ST_WAIT_WORD);
  assign lif.pgrm_addr  = (state_reg == ST_ADDR);
  assign lif.pgrm_data  = (state_reg == ST_DATA);
  assign lif.running    = running;
  assign lif.done       = (state_reg == ST_HALTED);
  assign lif.bus_oe     = (state_reg == ST_ADDR) | (state_reg == ST_DATA) | io_bus_oe;

  always_comb begin
    lif.bus_out = '0;
    case (state_reg)
      ST_ADDR: lif.bus_out = DATA_W'(addr_reg);
      ST_DATA: lif.bus_out = word_reg;
      ST_RUN:  lif.bus_out = io_bus_out;
      default: lif.bus_out = '0;
    endcase
  end
endmodule

// File: tb/tb_hmmm_loader.sv
// Directed testbench for hmmm_loader. A negedge monitor models the core RAM
// writes; the core's in/out/halt behaviour is driven directly by the tasks.
module tb_hmmm_loader;
  import hmmm_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  hmmm_loader_if lif ();

  hmmm_loader dut (
    .clk (clk),
    .rst (rst),
    .lif (lif)
  );

  logic [15:0] ram [0:255];
  logic [15:0] words [0:255];
  logic [7:0]  cur_addr = 8'd0;
  int          addr_log[$];
  logic [15:0] data_log[$];
  int          overlap_cnt = 0;
  int          oe_conflict_cnt = 0;
  int          load_side_cnt = 0;

  always @(negedge clk) begin
    if (lif.pgrm_addr && lif.pgrm_data) overlap_cnt++;
    if (lif.core_write && lif.bus_oe) oe_conflict_cnt++;
    if ((lif.pgrm_addr || lif.pgrm_data) && (lif.word_ready || !lif.bus_oe)) load_side_cnt++;
    if (lif.pgrm_addr) begin
      cur_addr = lif.bus_out[7:0];
      addr_log.push_back(int'(lif.bus_out[7:0]));
    end
    if (lif.pgrm_data) begin
      ram[cur_addr] = lif.bus_out;
      data_log.push_back(lif.bus_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_abort();
    lif.abort = 1'b1;
    tick();
    lif.abort = 1'b0;
  endtask

  // Streams words[0..len-1]; word_valid follows pat bit by bit. Returns the
  // number of cycles spent in WAIT_WORD/ADDR/DATA. Ends aligned after a posedge.
  task automatic do_load(input int len, input logic [15:0] pat, output int cycles, output int timeout);
    int idx;
    logic acc;
    addr_log.delete();
    data_log.delete();
    idx = 0;
    lif.load_len   = 8'(len);
    lif.load_start = 1'b1;
    lif.word_data  = words[0];
    lif.word_valid = pat[0];
    tick();
    lif.load_start = 1'b0;
    cycles  = 0;
    timeout = 1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (lif.running) begin
        timeout = 0;
        break;
      end
      if (lif.word_ready || lif.pgrm_addr || lif.pgrm_data) cycles++;
      acc = lif.word_ready & lif.word_valid;
      tick();
      if (acc && idx < 255) idx++;
      lif.word_data  = words[idx];
      lif.word_valid = pat[(c + 1) % 16];
    end
    lif.word_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    flags = {lif.word_ready, lif.pgrm_addr, lif.pgrm_data, lif.bus_oe, lif.running,
             lif.done, lif.out_valid, lif.io_underflow, lif.in_ready};
    total++; if (lif.core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst got=%b exp=1", lif.core_rst); end
    total++; if (flags !== 9'd0) begin bad++; $display("FAIL reset_flags got=%b exp=000000000", flags); end
    total++; if (lif.bus_out !== 16'h0) begin bad++; $display("FAIL reset_bus_out got=%h exp=0000", lif.bus_out); end
    total++; if (lif.out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", lif.out_data); end
    // Start a load and hit rst while the address cycle is on the bus.
    tick();
    lif.load_len = 8'd2; lif.word_data = 16'h1111; lif.word_valid = 1'b1; lif.load_start = 1'b1;
    tick();
    lif.load_start = 1'b0;
    tick();
    @(negedge clk);
    total++; if (lif.pgrm_addr !== 1'b1) begin bad++; $display("FAIL reset_pre_addr got=%b exp=1", lif.pgrm_addr); end
    #1 rst = 1'b1;
    #1;
    total++; if (lif.core_rst !== 1'b1) begin bad++; $display("FAIL async_core_rst got=%b exp=1", lif.core_rst); end
    total++; if ({lif.pgrm_addr, lif.pgrm_data} !== 2'b00) begin bad++; $display("FAIL async_pgrm got=%b exp=00", {lif.pgrm_addr, lif.pgrm_data}); end
    total++; if (lif.bus_oe !== 1'b0) begin bad++; $display("FAIL async_bus_oe got=%b exp=0", lif.bus_oe); end
    tick();
    rst = 1'b0;
    lif.word_valid = 1'b0;
    @(negedge clk);
    total++; if ({lif.core_rst, lif.word_ready, lif.running} !== 3'b100) begin bad++; $display("FAIL reset_idle got=%b exp=100", {lif.core_rst, lif.word_ready, lif.running}); end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_load3();
    int cycles, timeout;
    words[0] = 16'h1201; words[1] = 16'h2202; words[2] = 16'h0000;
    load_side_cnt = 0;
    do_load(3, 16'hFFFF, cycles, timeout);
    total++; if (timeout !== 0) begin bad++; $display("FAIL load3_timeout got=%0d exp=0", timeout); end
    total++; if (cycles !== 9) begin bad++; $display("FAIL load3_cycles got=%0d exp=9", cycles); end
    total++; if (addr_log.size() !== 3) begin bad++; $display("FAIL load3_addr_count got=%0d exp=3", addr_log.size()); end
    for (int i = 0; i < 3 && i < addr_log.size(); i++) begin
      total++; if (addr_log[i] !== i) begin bad++; $display("FAIL load3_addr[%0d] got=%0d exp=%0d", i, addr_log[i], i); end
    end
    for (int i = 0; i < 3 && i < data_log.size(); i++) begin
      total++; if (data_log[i] !== words[i]) begin bad++; $display("FAIL load3_data[%0d] got=%h exp=%h", i, data_log[i], words[i]); end
    end
    total++; if (ram[1] !== 16'h2202) begin bad++; $display("FAIL load3_ram1 got=%h exp=2202", ram[1]); end
    total++; if (load_side_cnt !== 0) begin bad++; $display("FAIL load3_ready_or_oe got=%0d exp=0", load_side_cnt); end
    total++; if (lif.running !== 1'b1) begin bad++; $display("FAIL load3_running got=%b exp=1", lif.running); end
    $display("test_load3 cycles=%0d", cycles);
  endtask

  task automatic test_run_io();
    oe_conflict_cnt = 0;
    lif.core_read = 1'b1; lif.in_valid = 1'b1; lif.in_data = 16'h00A5;
    @(negedge clk);
    total++; if (lif.in_ready !== 1'b1) begin bad++; $display("FAIL io_in_ready got=%b exp=1", lif.in_ready); end
    total++; if ({lif.bus_oe, lif.bus_out} !== {1'b1, 16'h00A5}) begin bad++; $display("FAIL io_in_bus got=%b/%h exp=1/00a5", lif.bus_oe, lif.bus_out); end
    tick();
    lif.core_read = 1'b0; lif.in_valid = 1'b0; lif.core_write = 1'b1; lif.bus_in = 16'h00A5;
    @(negedge clk);
    total++; if (lif.bus_oe !== 1'b0) begin bad++; $display("FAIL io_write_oe got=%b exp=0", lif.bus_oe); end
    tick();
    lif.core_write = 1'b0; lif.bus_in = 16'h0; lif.core_halt = 1'b1;
    @(negedge clk);
    total++; if ({lif.out_valid, lif.out_data} !== {1'b1, 16'h00A5}) begin bad++; $display("FAIL io_out got=%b/%h exp=1/00a5", lif.out_valid, lif.out_data); end
    tick();
    lif.core_halt = 1'b0;
    @(negedge clk);
    total++; if ({lif.done, lif.running, lif.out_valid, lif.core_rst} !== 4'b1000) begin bad++; $display("FAIL io_halted got=%b exp=1000", {lif.done, lif.running, lif.out_valid, lif.core_rst}); end
    total++; if (oe_conflict_cnt !== 0) begin bad++; $display("FAIL io_oe_conflict got=%0d exp=0", oe_conflict_cnt); end
    tick();
    $display("test_run_io done");
  endtask

  task automatic test_underflow();
    lif.load_len = 8'd0; lif.load_start = 1'b1;
    tick();
    lif.load_start = 1'b0;
    @(negedge clk);
    total++; if ({lif.core_rst, lif.running, lif.done} !== 3'b100) begin bad++; $display("FAIL uf_rstc got=%b exp=100", {lif.core_rst, lif.running, lif.done}); end
    tick();
    @(negedge clk);
    total++; if ({lif.running, lif.core_rst} !== 2'b10) begin bad++; $display("FAIL uf_run got=%b exp=10", {lif.running, lif.core_rst}); end
    tick();
    lif.core_read = 1'b1; lif.in_valid = 1'b0; lif.in_data = 16'hBEEF;
    @(negedge clk);
    total++; if ({lif.in_ready, lif.bus_out} !== {1'b0, 16'h0}) begin bad++; $display("FAIL uf_starved got=%b/%h exp=0/0000", lif.in_ready, lif.bus_out); end
    tick();
    lif.core_read = 1'b0;
    @(negedge clk);
    total++; if (lif.io_underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%b exp=1", lif.io_underflow); end
    tick();
    @(negedge clk);
    total++; if (lif.io_underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", lif.io_underflow); end
    tick();
    // Halt in the same cycle as an out instruction: the word still comes out.
    lif.core_halt = 1'b1; lif.core_write = 1'b1; lif.bus_in = 16'h1234;
    tick();
    lif.core_halt = 1'b0; lif.core_write = 1'b0; lif.bus_in = 16'h0;
    @(negedge clk);
    total++; if ({lif.done, lif.out_valid, lif.out_data} !== {2'b11, 16'h1234}) begin bad++; $display("FAIL uf_halt_write got=%b%b/%h exp=11/1234", lif.done, lif.out_valid, lif.out_data); end
    tick();
    lif.load_len = 8'd0; lif.load_start = 1'b1;
    tick();
    lif.load_start = 1'b0;
    @(negedge clk);
    total++; if ({lif.core_rst, lif.io_underflow, lif.done} !== 3'b100) begin bad++; $display("FAIL uf_clear got=%b exp=100", {lif.core_rst, lif.io_underflow, lif.done}); end
    tick();
    @(negedge clk);
    total++; if ({lif.running, lif.core_rst} !== 2'b10) begin bad++; $display("FAIL uf_rerun got=%b exp=10", {lif.running, lif.core_rst}); end
    tick();
    $display("test_underflow done");
  endtask

  task automatic test_backpressure();
    int cycles, timeout;
    pulse_abort();
    for (int i = 0; i < 6; i++) words[i] = 16'hA000 + 16'(i * 17);
    overlap_cnt = 0;
    do_load(6, 16'b0110_1001_1100_0101, cycles, timeout);
    total++; if (timeout !== 0) begin bad++; $display("FAIL bp_timeout got=%0d exp=0", timeout); end
    total++; if (data_log.size() !== 6) begin bad++; $display("FAIL bp_word_count got=%0d exp=6", data_log.size()); end
    for (int i = 0; i < 6; i++) begin
      total++; if (ram[i] !== words[i]) begin bad++; $display("FAIL bp_ram[%0d] got=%h exp=%h", i, ram[i], words[i]); end
    end
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL bp_overlap got=%0d exp=0", overlap_cnt); end
    $display("test_backpressure cycles=%0d", cycles);
  endtask

  task automatic test_boundaries();
    int cycles, timeout;
    int n;
    // load_start while running is ignored
    lif.load_len = 8'd4; lif.load_start = 1'b1;
    tick();
    lif.load_start = 1'b0;
    @(negedge clk);
    total++; if ({lif.running, lif.word_ready} !== 2'b10) begin bad++; $display("FAIL bnd_start_in_run got=%b exp=10", {lif.running, lif.word_ready}); end
    tick();
    pulse_abort();
    @(negedge clk);
    total++; if ({lif.core_rst, lif.running} !== 2'b10) begin bad++; $display("FAIL bnd_abort_run got=%b exp=10", {lif.core_rst, lif.running}); end
    tick();
    // zero length goes straight to RUN from IDLE
    lif.load_len = 8'd0; lif.load_start = 1'b1;
    tick();
    lif.load_start = 1'b0;
    @(negedge clk);
    total++; if ({lif.running, lif.word_ready, lif.core_rst} !== 3'b100) begin bad++; $display("FAIL bnd_len0 got=%b exp=100", {lif.running, lif.word_ready, lif.core_rst}); end
    tick();
    pulse_abort();
    // maximum length fills 0..254
    for (int i = 0; i < 256; i++) words[i] = 16'h5500 ^ 16'(i);
    do_load(255, 16'hFFFF, cycles, timeout);
    n = addr_log.size();
    total++; if (timeout !== 0) begin bad++; $display("FAIL bnd_255_timeout got=%0d exp=0", timeout); end
    total++; if (n !== 255) begin bad++; $display("FAIL bnd_255_count got=%0d exp=255", n); end
    if (n > 0) begin
      total++; if (addr_log[n-1] !== 254) begin bad++; $display("FAIL bnd_255_last_addr got=%0d exp=254", addr_log[n-1]); end
    end
    total++; if (ram[254] !== 16'h55FE) begin bad++; $display("FAIL bnd_255_ram got=%h exp=55fe", ram[254]); end
    pulse_abort();
    // abort during the data cycle
    words[0] = 16'h0F0F; words[1] = 16'hF0F0;
    lif.load_len = 8'd2; lif.load_start = 1'b1; lif.word_data = words[0]; lif.word_valid = 1'b1;
    tick();
    lif.load_start = 1'b0;
    timeout = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (lif.pgrm_data) begin
        timeout = 0;
        break;
      end
    end
    total++; if (timeout !== 0) begin bad++; $display("FAIL bnd_abort_reach_data got=%0d exp=0", timeout); end
    lif.abort = 1'b1;
    tick();
    lif.abort = 1'b0;
    lif.word_valid = 1'b0;
    @(negedge clk);
    total++; if ({lif.core_rst, lif.pgrm_data, lif.word_ready, lif.running} !== 4'b1000) begin bad++; $display("FAIL bnd_abort_data got=%b exp=1000", {lif.core_rst, lif.pgrm_data, lif.word_ready, lif.running}); end
    tick();
    @(negedge clk);
    total++; if ({lif.core_rst, lif.pgrm_addr, lif.word_ready} !== 3'b100) begin bad++; $display("FAIL bnd_abort_stays got=%b exp=100", {lif.core_rst, lif.pgrm_addr, lif.word_ready}); end
    tick();
    $display("test_boundaries cycles255=%0d", cycles);
  endtask

  initial begin
    lif.load_start = 1'b0; lif.abort = 1'b0; lif.load_len = 8'd0;
    lif.word_valid = 1'b0; lif.word_data = 16'h0; lif.bus_in = 16'h0;
    lif.core_read = 1'b0; lif.core_write = 1'b0; lif.core_halt = 1'b0;
    lif.in_valid = 1'b0; lif.in_data = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_load3();
    test_run_io();
    test_underflow();
    test_backpressure();
    test_boundaries();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
